// File: rtl/dmi_req_sync_if.sv
// Event handshake bundle of dmi_req_sync: the synchronizer offers one
// channel event at a time (master side) and the consumer accepts it.
interface dmi_req_sync_if #(
  parameter int CH_W   = 1,
  parameter int DATA_W = 32
);
  logic              ev_valid_o;
  logic              ev_ready_i;
  logic [CH_W-1:0]   ev_ch_o;
  logic [DATA_W-1:0] ev_data_o;

  modport master (output ev_valid_o, ev_ch_o, ev_data_o, input ev_ready_i);
  modport slave  (input ev_valid_o, ev_ch_o, ev_data_o, output ev_ready_i);
endinterface

// File: rtl/dmi_req_sync.sv
// Multi-channel asynchronous request synchronizer with edge detect, pending
// bits, sticky overflow and a valid/ready event port. Payload capture is
// built only when DMI_SYNC_DATA_CAPTURE_EN is defined.
//
// state | meaning
// IDLE  | nothing offered; latch lowest pending channel when any is pending
// OFFER | event for sel_q offered until ev_ready_i
module dmi_req_sync #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32,
  parameter int EDGE_MODE   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [DATA_W-1:0] data_i,
  dmi_req_sync_if.master    ev,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] ovf_o,
  input  logic              ovf_clr_i
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_err_num_ch
    $error("dmi_req_sync: NUM_CH must be in 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_err_sync
    $error("dmi_req_sync: SYNC_STAGES must be in 2..4");
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_err_data_w
    $error("dmi_req_sync: DATA_W must be in 1..64");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_err_edge
    $error("dmi_req_sync: EDGE_MODE must be 0, 1 or 2");
  end

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   sel_q, sel_d, low_idx;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set;
  logic [NUM_CH-1:0] clr_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= req_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_MODE)
      0:       edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
      1:       edge_det = ~sync_q[SYNC_STAGES-1] & hist_q;
      default: edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;
    endcase
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = CH_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clr_vec = '0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          sel_d   = low_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ev.ev_ready_i) begin
          clr_vec = NUM_CH'(1) << sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An edge on a channel being acknowledged this cycle re-arms it instead of overflowing.
  always_comb begin
    ovf_set = edge_det & pend_q & ~clr_vec;
    pend_d  = (pend_q & ~clr_vec) | edge_det;
    ovf_d   = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ev.ev_valid_o = (state_q == OFFER);
  assign ev.ev_ch_o    = (state_q == OFFER) ? sel_q : '0;
  assign pend_o        = pend_q;
  assign ovf_o         = ovf_q;

`ifdef DMI_SYNC_DATA_CAPTURE_EN
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [NUM_CH-1:0] load_vec;

  assign load_vec = edge_det & ~ovf_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (load_vec[c]) data_q[c] <= data_i;
      end
    end
  end

  assign ev.ev_data_o = (state_q == OFFER) ? data_q[sel_q] : '0;
`else
  logic unused_data;
  assign unused_data  = ^data_i;
  assign ev.ev_data_o = '0;
`endif
endmodule
